// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the ALU dispatcher: FSM state
//                encoding, functional-unit select codes, opcode values and
//                the latched request record.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned UNIT_W = 3;
    localparam int unsigned OPC_W  = 4;

    // Dispatcher FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Functional-unit select codes; 3'b000 means "no unit" and is illegal
    // as a request target.
    localparam logic [UNIT_W-1:0] UNIT_NONE   = 3'b000;
    localparam logic [UNIT_W-1:0] UNIT_ADDSUB = 3'b001;
    localparam logic [UNIT_W-1:0] UNIT_LOGIC  = 3'b010;
    localparam logic [UNIT_W-1:0] UNIT_SHIFT  = 3'b011;
    localparam logic [UNIT_W-1:0] UNIT_MULT   = 3'b100;

    // Opcodes understood by the functional units
    localparam logic [OPC_W-1:0] OP_NOP       = 4'b0000;
    localparam logic [OPC_W-1:0] OP_INC       = 4'b0001;
    localparam logic [OPC_W-1:0] OP_ADD       = 4'b0010;
    localparam logic [OPC_W-1:0] OP_SUB       = 4'b0011;
    localparam logic [OPC_W-1:0] OP_DEC       = 4'b0100;
    localparam logic [OPC_W-1:0] OP_ONES_COMP = 4'b0101;

    // Request as held by the dispatcher while it is in flight
    typedef struct packed {
        logic [UNIT_W-1:0] sel;
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    function automatic logic unit_is_legal(input logic [UNIT_W-1:0] sel);
        return (sel != UNIT_NONE);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wait_timer
//  Description : Counts cycles spent waiting for a functional unit.
//                The count starts at 0 on the first enabled cycle and steps
//                once per enabled cycle. 'armed' says the ignore window has
//                elapsed; 'timeout' fires in the last permitted wait cycle so
//                the owner leaves WAIT on the edge the count reaches TIMEOUT.
//  Ports       : clk, reset_n  - clock, async active-low reset
//                clear         - synchronous return of the count to 0
//                enable        - count this cycle (owner is waiting)
//                armed         - count >= IGNORE (flag may be honoured)
//                timeout       - enabled and on the final wait cycle
//  Revision    : 1.0  initial release
// ============================================================================
module alu_wait_timer #(
    parameter int unsigned TIMEOUT = 4,   // must be >= 1
    parameter int unsigned IGNORE  = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic armed,
    output logic timeout
);

    // The count never exceeds TIMEOUT-1, so that is all it must hold.
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == C_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !w_at_last) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign armed   = (32'(r_count) >= IGNORE);
    assign timeout = enable && w_at_last;

endmodule : alu_wait_timer
`default_nettype wire

// File: rtl/alu_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : alu_dispatcher
//  Description : Accepts one operation request at a time, drives it to the
//                selected functional unit, waits (bounded) for the unit's
//                completion flag and returns the result or an error response.
//  Ports       : clk, reset_n                 - clock, async active-low reset
//                req_valid/req_ready          - request handshake
//                req_unit, req_opcode,
//                req_a, req_b                 - request fields
//                select, opcode, a, b         - drive to the functional units
//                flag, unit_result            - unit completion and result
//                rsp_valid/rsp_ready          - response handshake
//                rsp_result, rsp_error        - response payload
//                op_count                     - error-free responses, wraps
//  Revision    : 1.0  initial release
// ============================================================================
module alu_dispatcher
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 4,
    parameter int unsigned FLAG_IGNORE = 1
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [UNIT_W-1:0] req_unit,
    input  logic [OPC_W-1:0]  req_opcode,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,

    output logic [UNIT_W-1:0] select,
    output logic [OPC_W-1:0]  opcode,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    input  logic              flag,
    input  logic [DATA_W-1:0] unit_result,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_error,
    output logic [7:0]        op_count
);

    state_t            r_state;
    state_t            w_state_next;

    req_t              r_req;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_error;
    logic [7:0]        r_op_count;

    logic              w_accept;      // legal request latched this edge
    logic              w_reject;      // illegal unit: straight to error response
    logic              w_done_ok;     // qualifying flag seen in WAIT
    logic              w_done_err;    // wait expired without a qualifying flag
    logic              w_handshake;   // response consumed this edge

    logic              w_timer_clear;
    logic              w_timer_en;
    logic              w_timer_armed;
    logic              w_timer_expired;

    // ------------------------------------------------------------------
    // Wait-cycle timer
    // ------------------------------------------------------------------
    alu_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .IGNORE  (FLAG_IGNORE)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_timer_clear),
        .enable  (w_timer_en),
        .armed   (w_timer_armed),
        .timeout (w_timer_expired)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and unit-side / handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        select        = UNIT_NONE;
        opcode        = OP_NOP;
        a             = '0;
        b             = '0;
        w_accept      = 1'b0;
        w_reject      = 1'b0;
        w_done_ok     = 1'b0;
        w_done_err    = 1'b0;
        w_handshake   = 1'b0;
        w_timer_clear = 1'b1;
        w_timer_en    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Ready is held low while reset is asserted and rises the
                // moment it is released.
                req_ready = reset_n;
                if (req_valid) begin
                    if (unit_is_legal(req_unit)) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_ISSUE;
                    end else begin
                        w_reject     = 1'b1;
                        w_state_next = ST_RESP;
                    end
                end
            end

            ST_ISSUE: begin
                // Flag is not looked at here; a unit cannot have finished
                // an operation it has only just been handed.
                select       = r_req.sel;
                opcode       = r_req.opcode;
                a            = r_req.a;
                b            = r_req.b;
                w_state_next = ST_WAIT;
            end

            ST_WAIT: begin
                select        = r_req.sel;
                opcode        = r_req.opcode;
                a             = r_req.a;
                b             = r_req.b;
                w_timer_clear = 1'b0;
                w_timer_en    = 1'b1;
                // A qualifying flag takes priority over expiry on the
                // same edge.
                if (flag && w_timer_armed) begin
                    w_done_ok    = 1'b1;
                    w_state_next = ST_RESP;
                end else if (w_timer_expired) begin
                    w_done_err   = 1'b1;
                    w_state_next = ST_RESP;
                end
            end

            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latched request
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req <= '0;
        end else if (w_accept) begin
            r_req.sel    <= req_unit;
            r_req.opcode <= req_opcode;
            r_req.a      <= req_a;
            r_req.b      <= req_b;
        end
    end

    // ------------------------------------------------------------------
    // Response payload: only written on entry to RESP, so it stays
    // stable for as long as the consumer stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_result <= '0;
            r_rsp_error  <= 1'b0;
        end else if (w_reject || w_done_err) begin
            r_rsp_result <= '0;
            r_rsp_error  <= 1'b1;
        end else if (w_done_ok) begin
            r_rsp_result <= unit_result;
            r_rsp_error  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Completed error-free operation counter (natural 8-bit wrap)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_count <= 8'h00;
        end else if (w_handshake && !r_rsp_error) begin
            r_op_count <= r_op_count + 8'h01;
        end
    end

    assign rsp_result = r_rsp_result;
    assign rsp_error  = r_rsp_error;
    assign op_count   = r_op_count;

endmodule : alu_dispatcher
`default_nettype wire

// File: tb/tb_alu_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_dispatcher
//  Description : Directed self-checking bench for alu_dispatcher with
//                TIMEOUT=4 and FLAG_IGNORE=1. Inputs change and outputs are
//                observed on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_dispatcher;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_unit;
    logic [3:0] req_opcode;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [2:0] select;
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic       flag;
    logic [7:0] unit_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_error;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_err    = 0;

    alu_dispatcher #(
        .TIMEOUT     (4),
        .FLAG_IGNORE (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_unit    (req_unit),
        .req_opcode  (req_opcode),
        .req_a       (req_a),
        .req_b       (req_b),
        .select      (select),
        .opcode      (opcode),
        .a           (a),
        .b           (b),
        .flag        (flag),
        .unit_result (unit_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_error   (rsp_error),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input logic [2:0] u, input logic [3:0] op,
                           input logic [7:0] va, input logic [7:0] vb);
        req_valid  = 1'b1;
        req_unit   = u;
        req_opcode = op;
        req_a      = va;
        req_b      = vb;
    endtask

    // One fast operation: flag held high so it qualifies on the second
    // WAIT cycle; consumer accepts immediately.
    task automatic run_op(input logic [7:0] res);
        bit seen;
        set_req(3'b001, 4'b0001, res, 8'h00);
        flag        = 1'b1;
        unit_result = res;
        step();
        req_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (rsp_valid === 1'b1) seen = 1;
        end
        check("wrap_rsp_seen", 32'(seen), 32'd1);
        check("wrap_rsp_result", 32'(rsp_result), 32'(res));
        rsp_ready = 1'b1;
        flag      = 1'b0;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int seen_cnt;

        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_unit    = 3'b000;
        req_opcode  = 4'b0000;
        req_a       = 8'h00;
        req_b       = 8'h00;
        flag        = 1'b0;
        unit_result = 8'h00;
        rsp_ready   = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_select",    32'(select),    32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_op_count",  32'(op_count),  32'd0);
        reset_n = 1'b1;
        #1;
        check("rel_req_ready", 32'(req_ready), 32'd1);
        step();

        // ---------------- A: 5 + 3 = 8, minimum latency ----------------
        set_req(3'b001, 4'b0010, 8'd5, 8'd3);
        step();                                   // ISSUE
        req_valid = 1'b0;
        check("A_issue_select", 32'(select), 32'd1);
        check("A_issue_opcode", 32'(opcode), 32'd2);
        check("A_issue_a",      32'(a),      32'd5);
        check("A_issue_b",      32'(b),      32'd3);
        check("A_issue_ready",  32'(req_ready), 32'd0);
        flag = 1'b1; unit_result = 8'hEE;         // must be ignored
        step();                                   // WAIT cnt0
        check("A_wait0_valid",  32'(rsp_valid), 32'd0);
        check("A_wait0_select", 32'(select),    32'd1);
        step();                                   // WAIT cnt1 (flag at cnt0 ignored)
        check("A_ignore_valid", 32'(rsp_valid), 32'd0);
        unit_result = 8'h08;
        step();                                   // RESP, 3 cycles after accept
        check("A_rsp_valid",  32'(rsp_valid),  32'd1);
        check("A_rsp_result", 32'(rsp_result), 32'h08);
        check("A_rsp_error",  32'(rsp_error),  32'd0);
        check("A_rsp_select", 32'(select),     32'd0);
        check("A_rsp_ready",  32'(req_ready),  32'd0);
        flag = 1'b0; unit_result = 8'h00; rsp_ready = 1'b1;
        step();                                   // IDLE
        rsp_ready = 1'b0;
        check("A_idle_valid", 32'(rsp_valid), 32'd0);
        check("A_idle_ready", 32'(req_ready), 32'd1);
        check("A_op_count",   32'(op_count),  32'd1);

        // ---------------- C: illegal unit ----------------
        set_req(3'b000, 4'b0010, 8'd1, 8'd1);
        step();                                   // RESP directly
        req_valid = 1'b0;
        check("C_rsp_valid",  32'(rsp_valid),  32'd1);
        check("C_rsp_error",  32'(rsp_error),  32'd1);
        check("C_rsp_result", 32'(rsp_result), 32'd0);
        check("C_rsp_select", 32'(select),     32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("C_idle_select", 32'(select),   32'd0);
        check("C_op_count",    32'(op_count), 32'd1);

        // ---------------- D: flag arrives with the timeout edge ----------------
        set_req(3'b001, 4'b0011, 8'd9, 8'd4);
        step();                                   // ISSUE
        req_valid = 1'b0;
        check("D_issue_opcode", 32'(opcode), 32'd3);
        check("D_issue_a",      32'(a),      32'd9);
        check("D_issue_b",      32'(b),      32'd4);
        for (int k = 0; k < 4; k++) begin
            step();                               // WAIT cnt k
            check("D_wait_valid", 32'(rsp_valid), 32'd0);
        end
        flag = 1'b1; unit_result = 8'h05;         // present on final WAIT cycle
        step();
        check("D_rsp_valid",  32'(rsp_valid),  32'd1);
        check("D_rsp_error",  32'(rsp_error),  32'd0);
        check("D_rsp_result", 32'(rsp_result), 32'h05);
        flag = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("D_op_count", 32'(op_count), 32'd2);

        // ---------------- B: timeout, then consumer stall ----------------
        set_req(3'b010, 4'b0101, 8'hAA, 8'h00);
        step();                                   // ISSUE
        req_valid = 1'b0;
        check("B_issue_select", 32'(select), 32'd2);
        for (int k = 0; k < 4; k++) begin
            step();
            check("B_wait_valid", 32'(rsp_valid), 32'd0);
        end
        step();                                   // RESP after 4 WAIT cycles
        check("B_rsp_valid",  32'(rsp_valid),  32'd1);
        check("B_rsp_error",  32'(rsp_error),  32'd1);
        check("B_rsp_result", 32'(rsp_result), 32'd0);
        check("B_rsp_select", 32'(select),     32'd0);
        set_req(3'b001, 4'b0010, 8'd1, 8'd2);    // must be ignored
        flag = 1'b1; unit_result = 8'h55;
        for (int k = 0; k < 3; k++) begin
            step();
            check("B_stall_valid",  32'(rsp_valid),  32'd1);
            check("B_stall_result", 32'(rsp_result), 32'd0);
            check("B_stall_error",  32'(rsp_error),  32'd1);
            check("B_stall_ready",  32'(req_ready),  32'd0);
        end
        req_valid = 1'b0; flag = 1'b0; rsp_ready = 1'b1;
        step();                                   // IDLE
        rsp_ready = 1'b0;
        check("B_op_count",   32'(op_count),  32'd2);
        check("B_idle_ready", 32'(req_ready), 32'd1);
        step();
        check("B_no_accept_valid",  32'(rsp_valid), 32'd0);
        check("B_no_accept_select", 32'(select),    32'd0);

        // ---------------- E: reset during WAIT ----------------
        set_req(3'b001, 4'b0001, 8'd7, 8'd0);
        step();                                   // ISSUE
        req_valid = 1'b0;
        step();                                   // WAIT
        check("E_wait_select", 32'(select), 32'd1);
        reset_n = 1'b0;
        #1;
        check("E_rst_select",   32'(select),    32'd0);
        check("E_rst_a",        32'(a),         32'd0);
        check("E_rst_opcode",   32'(opcode),    32'd0);
        check("E_rst_ready",    32'(req_ready), 32'd0);
        check("E_rst_valid",    32'(rsp_valid), 32'd0);
        check("E_rst_op_count", 32'(op_count),  32'd0);
        flag = 1'b1; unit_result = 8'h77;
        step();
        reset_n = 1'b1;
        #1;
        check("E_rel_ready", 32'(req_ready), 32'd1);
        seen_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (rsp_valid !== 1'b0) seen_cnt++;
        end
        check("E_no_response", 32'(seen_cnt), 32'd0);
        check("E_op_count",    32'(op_count), 32'd0);
        flag = 1'b0;

        // ---------------- F: 256 successful ops wrap the counter ----------------
        for (int i = 0; i < 256; i++) begin
            run_op(8'(i));
            if (i == 254) check("F_count_ff", 32'(op_count), 32'hFF);
        end
        check("F_count_wrap", 32'(op_count), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_dispatcher
`default_nettype wire

// File: doc/alu_dispatcher.md
ALU_DISPATCHER -- requirements
Module: alu_dispatcher

Interface
REQ-001 Parameter: TIMEOUT, default 4, max WAIT cycles for Flag before error response.
REQ-002 Parameter: FLAG_IGNORE, default 1, cycles after ISSUE during which Flag is ignored.
REQ-003 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Req_Valid  in  1  operation request present.
REQ-006 Req_Ready  out  1  dispatcher accepts request this cycle.
REQ-007 Req_Unit  in  3  target functional-unit select code; 3'b000 illegal.
REQ-008 Req_Opcode  in  4  opcode for the target unit.
REQ-009 Req_A, Req_B  in  8 each  operands.
REQ-010 Select  out  3  unit select driven to functional units.
REQ-011 Opcode  out  4  opcode driven to functional units.
REQ-012 A, B  out  8 each  operands driven to functional units.
REQ-013 Flag  in  1  unit completion flag.
REQ-014 Unit_Result  in  8  unit result, valid when Flag=1.
REQ-015 Rsp_Valid  out  1  response present.
REQ-016 Rsp_Ready  in  1  consumer accepts response.
REQ-017 Rsp_Result  out  8  captured result; 0 on error.
REQ-018 Rsp_Error  out  1  1 = illegal unit or timeout.
REQ-019 Op_Count  out  8  count of completed error-free responses, wraps.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP, shall be the only states.
REQ-021 IDLE: Req_Ready=1; Select=3'b000, Opcode=0, A=B=0.
REQ-022 IDLE with Req_Valid=1 and Req_Unit!=0: latch request, next state ISSUE.
REQ-023 IDLE with Req_Valid=1 and Req_Unit=0: next state RESP, Rsp_Error=1, Rsp_Result=0, Select never driven nonzero.
REQ-024 Req_Ready shall be 0 in ISSUE, WAIT, RESP; no bypass, one operation in flight.
REQ-025 ISSUE: drive latched Select/Opcode/A/B for exactly one cycle, then WAIT; Flag ignored in ISSUE.
REQ-026 WAIT: keep driving latched Select/Opcode/A/B; wait counter increments each WAIT cycle from 0.
REQ-027 WAIT: Flag=1 sampled after FLAG_IGNORE WAIT cycles elapsed -> capture Unit_Result into Rsp_Result, Rsp_Error=0, next RESP.
REQ-028 WAIT: counter reaching TIMEOUT without qualifying Flag -> Rsp_Result=0, Rsp_Error=1, next RESP.
REQ-029 Flag=1 and timeout on the same edge: Flag wins (no error).
REQ-030 RESP: Rsp_Valid=1; Select=3'b000; Rsp_Result/Rsp_Error stable until handshake.
REQ-031 RESP with Rsp_Ready=1: handshake completes, next IDLE; Op_Count+1 if Rsp_Error=0.
REQ-032 Op_Count shall wrap 8'hFF -> 8'h00.
REQ-033 Minimum latency, unit flag one cycle after ISSUE, FLAG_IGNORE=1: request accept edge -> Rsp_Valid high 3 cycles later.

Reset
REQ-034 Reset_n=0 shall immediately force state IDLE and all outputs to 0 except Req_Ready, which becomes 1 on release.
REQ-035 Reset_n asserted mid-ISSUE/WAIT/RESP: in-flight operation discarded, no response, Op_Count=0.
REQ-036 Wait counter and latched request registers shall clear on reset.

Structure
REQ-037 Shared package alu_pkg shall hold FSM state enum, unit select codes (3'b001 adder/subtractor etc.), opcode constants (Increment 4'b0001, Addition 4'b0010, Subtraction 4'b0011, Decrement 4'b0100, OnesComplement 4'b0101).
REQ-038 Sub-module alu_wait_timer shall implement the WAIT counter with clear, enable and timeout output.

Verification
REQ-039 Unit 001, Opcode 0010, A=5, B=3, Flag+Unit_Result=8'h08 two cycles after accept -> Rsp_Result=8'h08, Rsp_Error=0, Op_Count=1.
REQ-040 Unit 001, Flag held 0, TIMEOUT=4 -> Rsp_Valid after 4 WAIT cycles, Rsp_Error=1, Rsp_Result=0, Op_Count unchanged.
REQ-041 Req_Unit=000 -> Rsp_Error=1 next cycle, Select stays 3'b000 throughout.
REQ-042 Rsp_Ready low 3 cycles in RESP -> Rsp_Valid, Rsp_Result stable, Req_Ready=0, new Req_Valid ignored.
REQ-043 Reset_n low during WAIT -> outputs 0 same cycle, no response after release, Op_Count=0.
REQ-044 256 successful ops -> Op_Count returns to 8'h00.
